// File: rtl/vdp1_cmd_walker.sv
// VDP1 command-list walker: fetches 32-byte tables from VRAM at 0, applies END/skip/jump, hands tables to the draw engine.
// Latency: 1 cycle START->first request; 2 cycles per VRAM read (ack, then a one-cycle gap); 1 cycle per JUMP.
// Backpressure: MEM_REQ/MEM_ADDR held until MEM_ACK; CMD held in EXEC until CMD_DONE. Option: VDP1_CMD_CALL_NEST_EN.
// CMD packing: word 0 (CMDCTRL) in CMD[255:240] ... word 14 in CMD[31:16]; word 15 (UNUSED) is always 0.
module vdp1_cmd_walker #(
  parameter int STACK_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  output logic         MEM_REQ,
  output logic [17:0]  MEM_ADDR,
  input  logic         MEM_ACK,
  input  logic [15:0]  MEM_DATA,
  output logic         CMD_VALID,
  output logic [255:0] CMD,
  input  logic         CMD_DONE,
  output logic         BUSY,
  output logic [15:0]  COPR,
  output logic [15:0]  LOPR,
  output logic         CEF,
  output logic         BEF
);

  typedef enum logic [2:0] {IDLE, RD_CTRL, RD_LINK, RD_BODY, EXEC, JUMP} state_t;

  state_t              state, state_nxt;
  logic                got;        // word captured last cycle, decide this cycle
  logic [3:0]          widx;       // body word index 2..14
  logic [18:0]         ta;         // current table byte address
  logic [0:15][15:0]   tbl;        // fetched table, word 0 first
  logic [18:0]         ta_inc;
  logic [18:0]         link_ta;
  logic [18:0]         ta_nxt;
  logic [2:0]          jp;
  logic                end_bit;
  logic                comm_ok;
  logic                skip;
  logic                ack;
  logic                do_push;

`ifdef VDP1_CMD_CALL_NEST_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  logic [18:0]         stk [STACK_DEPTH];
  logic [SP_W-1:0]     sp;
  logic                do_pop;
`else
  logic [18:0]         ret;
  // STACK_DEPTH only sizes the nested stack; the single return register does not use it.
  if (STACK_DEPTH < 1) begin : g_depth_unused
  end
`endif

  assign end_bit = tbl[0][15];
  assign jp      = tbl[0][14:12];
  assign ack     = MEM_REQ && MEM_ACK;
  assign ta_inc  = ta + 19'h00020;
  // Low two CMDLINK bits are masked, so every target is 32-byte aligned.
  assign link_ta = {tbl[1][15:2], 2'b00, 3'b000};
  assign skip    = jp[2] || !comm_ok;
  assign do_push = (state == JUMP) && (jp[1:0] == 2'b10);
  assign COPR    = ta[18:3];
  assign CMD     = tbl;

  // Drawable command codes; anything else is handled like a skip.
  always_comb begin
    comm_ok = 1'b0;
    case (tbl[0][3:0])
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: comm_ok = 1'b1;
      default: comm_ok = 1'b0;
    endcase
  end

  // Next table address chosen by the jump mode.
  always_comb begin
    ta_nxt = ta_inc;
    case (jp[1:0])
      2'b01, 2'b10: ta_nxt = link_ta;
`ifdef VDP1_CMD_CALL_NEST_EN
      2'b11: ta_nxt = (sp == '0) ? ta_inc : stk[0];
`else
      2'b11: ta_nxt = ret;
`endif
      default: ta_nxt = ta_inc;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    BUSY      = (state != IDLE);
    CMD_VALID = (state == EXEC);
    case (state)
      IDLE:    if (START) state_nxt = RD_CTRL;
      RD_CTRL: if (got) state_nxt = end_bit ? IDLE : RD_LINK;
      RD_LINK: if (got) state_nxt = skip ? JUMP : RD_BODY;
      RD_BODY: if (ack && (widx == 4'd14)) state_nxt = EXEC;
      EXEC:    if (CMD_DONE) state_nxt = JUMP;
      JUMP:    state_nxt = RD_CTRL;
      default: state_nxt = IDLE;
    endcase
  end

  // Read port, table capture, table address and status registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
      got      <= 1'b0;
      widx     <= '0;
      ta       <= '0;
      tbl      <= '0;
      LOPR     <= '0;
      CEF      <= 1'b0;
      BEF      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            ta       <= '0;
            BEF      <= CEF;
            CEF      <= 1'b0;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= '0;
          end
        end
        RD_CTRL: begin
          if (!got) begin
            if (ack) begin
              MEM_REQ <= 1'b0;
              tbl[0]  <= MEM_DATA;
              got     <= 1'b1;
            end
          end else begin
            got <= 1'b0;
            if (end_bit) begin
              CEF <= 1'b1;
            end else begin
              MEM_REQ  <= 1'b1;
              MEM_ADDR <= {ta[18:5], 4'd1};
            end
          end
        end
        RD_LINK: begin
          if (!got) begin
            if (ack) begin
              MEM_REQ <= 1'b0;
              tbl[1]  <= MEM_DATA;
              got     <= 1'b1;
            end
          end else begin
            got <= 1'b0;
            if (!skip) begin
              MEM_REQ  <= 1'b1;
              MEM_ADDR <= {ta[18:5], 4'd2};
              widx     <= 4'd2;
            end
          end
        end
        RD_BODY: begin
          if (MEM_REQ) begin
            if (MEM_ACK) begin
              MEM_REQ   <= 1'b0;
              tbl[widx] <= MEM_DATA;
              if (widx == 4'd14) LOPR <= ta[18:3];
              else               widx <= widx + 4'd1;
            end
          end else begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= {ta[18:5], widx};
          end
        end
        JUMP: begin
          ta       <= ta_nxt;
          MEM_REQ  <= 1'b1;
          MEM_ADDR <= ta_nxt[18:1];
        end
        default: ;
      endcase
    end
  end

`ifdef VDP1_CMD_CALL_NEST_EN
  assign do_pop = (state == JUMP) && (jp[1:0] == 2'b11);

  // Return stack: a push shifts down (oldest entry lost when full), a pop shifts up.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else if (do_push) begin
      stk[0] <= ta_inc;
      for (int i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
      if (sp != SP_W'(STACK_DEPTH)) sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
      stk[STACK_DEPTH-1] <= '0;
      if (sp != '0) sp <= sp - SP_W'(1);
    end
  end
`else
  // Single return register: each call overwrites it, a return always loads it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       ret <= '0;
    else if (do_push) ret <= ta_inc;
  end
`endif

endmodule

// File: tb/tb_vdp1_cmd_walker.sv
// Bench for vdp1_cmd_walker: VRAM model with programmable ack delay and a draw-engine model.
// Expected read addresses and command tables are queued when a scenario is set up and popped as the DUT produces them.
// Scenarios: END at 0, next chain, call/return, assign+skip, nested calls, delayed ack with reset during EXEC.
module tb_vdp1_cmd_walker;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic         MEM_REQ;
  logic [17:0]  MEM_ADDR;
  logic         MEM_ACK = 1'b0;
  logic [15:0]  MEM_DATA = 16'h0;
  logic         CMD_VALID;
  logic [255:0] CMD;
  logic         CMD_DONE = 1'b0;
  logic         BUSY;
  logic [15:0]  COPR;
  logic [15:0]  LOPR;
  logic         CEF;
  logic         BEF;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int ack_dly = 0;
  int done_dly = 2;
  int wcnt = 0;
  int dcnt = 0;
  bit seen = 1'b0;
  logic [17:0] hold_addr = '0;

  logic [15:0]  vram [int];
  int           exp_addr [$];
  logic [255:0] exp_cmd [$];
  logic [15:0]  exp_lopr [$];

  vdp1_cmd_walker #(.STACK_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_DONE(CMD_DONE),
    .BUSY(BUSY), .COPR(COPR), .LOPR(LOPR), .CEF(CEF), .BEF(BEF)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(input int a);
    if (vram.exists(a)) return vram[a];
    return 16'h0;
  endfunction

  function automatic logic [255:0] tbl_of(input int ba);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) r[255-16*i -: 16] = rd(ba / 2 + i);
    return r;
  endfunction

  task automatic put_tbl(input int ba, input logic [15:0] ctrl, input logic [15:0] link);
    int w;
    w = ba / 2;
    vram[w] = ctrl;
    vram[w+1] = link;
    for (int i = 2; i < 15; i++) vram[w+i] = 16'(w * 3 + i) ^ 16'hC35A;
    vram[w+15] = 16'hDEAD;
  endtask

  task automatic put_end(input int ba);
    vram[ba / 2] = 16'h8000;
  endtask

  task automatic exp_full(input int ba);
    for (int i = 0; i < 15; i++) exp_addr.push_back(ba / 2 + i);
    exp_cmd.push_back(tbl_of(ba));
    exp_lopr.push_back(16'(ba >> 3));
  endtask

  task automatic exp_skip(input int ba);
    exp_addr.push_back(ba / 2);
    exp_addr.push_back(ba / 2 + 1);
  endtask

  task automatic exp_end(input int ba);
    exp_addr.push_back(ba / 2);
  endtask

  task automatic do_start(input logic exp_bef);
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    chk("start_req", 256'(MEM_REQ), 256'(1));
    chk("start_addr", 256'(MEM_ADDR), 256'(0));
    chk("start_busy", 256'(BUSY), 256'(1));
    chk("start_bef", 256'(BEF), 256'(exp_bef));
    chk("start_cef", 256'(CEF), 256'(0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) chk("idle_timeout", 256'(BUSY), 256'(0));
    chk("rd_left", 256'(exp_addr.size()), 256'(0));
    chk("cmd_left", 256'(exp_cmd.size()), 256'(0));
  endtask

  task automatic end_state(input logic [15:0] copr, input logic [15:0] lopr);
    chk("cef_end", 256'(CEF), 256'(1));
    chk("copr_end", 256'(COPR), 256'(copr));
    chk("lopr_end", 256'(LOPR), 256'(lopr));
  endtask

  // VRAM model: acks after ack_dly waiting cycles and checks each address against the queue.
  initial begin
    forever begin
      @(negedge CLK);
      if (MEM_ACK) begin
        MEM_ACK = 1'b0;
      end else if (MEM_REQ) begin
        if (wcnt == 0) hold_addr = MEM_ADDR;
        else chk("addr_hold", 256'(MEM_ADDR), 256'(hold_addr));
        if (wcnt == ack_dly) begin
          wcnt = 0;
          MEM_ACK = 1'b1;
          MEM_DATA = rd(int'(MEM_ADDR));
          last_ack_cyc = cyc;
          if (exp_addr.size() == 0) chk("rd_unexp", 256'(MEM_REQ), 256'(0));
          else chk("rd_addr", 256'(MEM_ADDR), 256'(exp_addr.pop_front()));
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Draw-engine model: checks each presented table, then signals done after done_dly cycles.
  initial begin
    forever begin
      @(negedge CLK);
      if (CMD_DONE) begin
        CMD_DONE = 1'b0;
        chk("vld_fall", 256'(CMD_VALID), 256'(0));
        seen = 1'b0;
      end else if (CMD_VALID) begin
        if (!seen) begin
          seen = 1'b1;
          dcnt = 0;
          chk("vld_rise", 256'(cyc - last_ack_cyc), 256'(1));
          if (exp_cmd.size() == 0) begin
            chk("cmd_unexp", 256'(CMD_VALID), 256'(0));
          end else begin
            chk("cmd", CMD, exp_cmd.pop_front());
            chk("lopr", 256'(LOPR), 256'(exp_lopr.pop_front()));
          end
        end
        if (dcnt == done_dly) CMD_DONE = 1'b1;
        else dcnt++;
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_req", 256'(MEM_REQ), 256'(0));
    chk("rst_addr", 256'(MEM_ADDR), 256'(0));
    chk("rst_vld", 256'(CMD_VALID), 256'(0));
    chk("rst_cmd", CMD, 256'(0));
    chk("rst_busy", 256'(BUSY), 256'(0));
    chk("rst_copr", 256'(COPR), 256'(0));
    chk("rst_lopr", 256'(LOPR), 256'(0));
    chk("rst_cef", 256'(CEF), 256'(0));
    chk("rst_bef", 256'(BEF), 256'(0));
    RST_N = 1'b1;

    // END at table 0: a single read, idle two cycles after its ack.
    vram.delete();
    put_end(0);
    exp_end(0);
    do_start(1'b0);
    wait_idle();
    chk("end_lat", 256'(cyc - last_ack_cyc), 256'(2));
    chk("end_bef", 256'(BEF), 256'(0));
    end_state(16'h0000, 16'h0000);

    // Next chain: POLY at 0 then END at 0x20.
    vram.delete();
    put_tbl(0, 16'h0004, 16'h0000);
    put_end(32'h20);
    exp_full(0);
    exp_end(32'h20);
    do_start(1'b1);
    wait_idle();
    end_state(16'h0004, 16'h0000);

    // Call to 0x100, return from there lands on 0x20.
    vram.delete();
    put_tbl(0, 16'h2000, 16'h0020);
    put_tbl(32'h100, 16'h3001, 16'h0000);
    put_end(32'h20);
    exp_full(0);
    exp_full(32'h100);
    exp_end(32'h20);
    do_start(1'b1);
    wait_idle();
    end_state(16'h0004, 16'h0020);

    // Skip+assign with masked link bits to 0x80, invalid COMM there is skipped, END at 0xA0.
    vram.delete();
    put_tbl(0, 16'h5000, 16'h0013);
    put_tbl(32'h80, 16'h0003, 16'h0000);
    put_end(32'hA0);
    exp_skip(0);
    exp_skip(32'h80);
    exp_end(32'hA0);
    do_start(1'b1);
    wait_idle();
    end_state(16'h0014, 16'h0020);

    // Nested calls through skipped tables.
    vram.delete();
    put_tbl(0, 16'h6000, 16'h0040);
    put_tbl(32'h200, 16'h6000, 16'h0080);
`ifdef VDP1_CMD_CALL_NEST_EN
    put_tbl(32'h400, 16'h6000, 16'h00C0);
    put_tbl(32'h600, 16'h7000, 16'h0000);
    put_tbl(32'h420, 16'h7000, 16'h0000);
    put_tbl(32'h220, 16'h7000, 16'h0000);
    put_end(32'h20);
    exp_skip(0);
    exp_skip(32'h200);
    exp_skip(32'h400);
    exp_skip(32'h600);
    exp_skip(32'h420);
    exp_skip(32'h220);
    exp_end(32'h20);
    do_start(1'b1);
    wait_idle();
    end_state(16'h0004, 16'h0020);
`else
    put_tbl(32'h400, 16'h7000, 16'h0000);
    put_end(32'h220);
    exp_skip(0);
    exp_skip(32'h200);
    exp_skip(32'h400);
    exp_end(32'h220);
    do_start(1'b1);
    wait_idle();
    end_state(16'h0044, 16'h0020);
`endif

    // Slow VRAM, then an asynchronous reset while a command is on offer.
    vram.delete();
    put_tbl(0, 16'h5000, 16'h0008);
    put_tbl(32'h40, 16'h0004, 16'h0000);
    exp_skip(0);
    exp_full(32'h40);
    ack_dly = 5;
    done_dly = 30;
    do_start(1'b1);
    n = 0;
    while (!CMD_VALID && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_VALID) chk("exec_timeout", 256'(CMD_VALID), 256'(1));
    #2 RST_N = 1'b0;
    #1;
    chk("arst_vld", 256'(CMD_VALID), 256'(0));
    chk("arst_busy", 256'(BUSY), 256'(0));
    chk("arst_req", 256'(MEM_REQ), 256'(0));
    chk("arst_cmd", CMD, 256'(0));
    chk("arst_lopr", 256'(LOPR), 256'(0));
    chk("arst_copr", 256'(COPR), 256'(0));
    chk("arst_bef", 256'(BEF), 256'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    exp_addr.delete();
    exp_cmd.delete();
    exp_lopr.delete();
    ack_dly = 0;
    done_dly = 2;

    // Walk again after reset: END at 0, BEF comes from the cleared CEF.
    vram.delete();
    put_end(0);
    exp_end(0);
    do_start(1'b0);
    wait_idle();
    end_state(16'h0000, 16'h0000);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
